dm_cache_wt: RTL and testbench
==============================

# dm_cache_wt

Parametrised direct-mapped, write-through, write-allocate cache between the CPU load/store port and the backing word memory. Replaces fixed-geometry combinational caching with a registered valid/ready request port, a multi-cycle miss path against a handshaked memory port, and a single-cycle flush. One outstanding CPU request at a time.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width in bits (2 bytes per word; addr[0] ignored)
- LINES, 256, number of one-word lines (power of two, ≥2)
- IDX_W, $clog2(LINES), index width (derived, do not override)
- TAG_W, ADDR_W-IDX_W-1, tag width (derived)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU request present
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  request accepted when req_valid && req_ready
- flush  in  1  invalidate all lines
- resp_valid  out  1  one-cycle pulse: load data valid / store complete
- resp_data  out  DATA_W  load data (0 on store responses)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned byte address (bit 0 = 0)
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready && !mem_we

## Operation
- Address split: index = addr[IDX_W:1], tag = addr[ADDR_W-1:IDX_W+1].
- FSM states: IDLE, FILL, WRITE. req_ready = 1 only in IDLE and flush low.
- IDLE, load accepted, hit (valid && tag match): resp_valid=1, resp_data=line next cycle; stay IDLE.
- IDLE, load accepted, miss: latch addr, go FILL. FILL drives mem_req=1, mem_we=0; on mem_ready write line (valid=1, tag, data), resp_data=mem_rdata, resp_valid pulse next cycle, return IDLE.
- IDLE, store accepted (hit or miss): line written immediately (valid=1, tag, data = req_wdata), go WRITE. WRITE drives mem_req=1, mem_we=1, mem_wdata; on mem_ready resp_valid pulse next cycle, return IDLE.
- mem_addr/mem_we/mem_wdata stable for whole mem_req assertion.
- flush in IDLE: all valid bits cleared in one cycle; takes priority over a simultaneous request (request not accepted). flush outside IDLE ignored.
- Reset: state IDLE, all valid bits 0, req_ready=1, resp_valid=0, resp_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-FILL/WRITE abandons transaction; mem_req low the cycle after reset asserts; no resp_valid issued.
- Tag/data arrays not reset.

## Timing
- Load hit: 1 cycle acceptance-to-resp_valid.
- Miss / store: mem_req rises cycle after acceptance; resp_valid exactly 1 cycle after mem_ready cycle; back-to-back request accepted that same resp cycle.
- mem_ready when mem_req=0 ignored.
- resp_valid never high two consecutive cycles for one request.

## Configuration
- CACHE_STATS_EN defined: extra outputs hit_count, miss_count (32 bit each, saturating at 0xFFFFFFFF, reset 0); counted per accepted load only (stores not counted); flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package cache_pkg: state enum (IDLE/FILL/WRITE), default width constants, address-split helper functions.
- Sub-module cache_line_store: valid/tag/data arrays with single write port, flush-clear and combinational lookup (hit, data) by index/tag.

## Test plan
- Reset, load 0x0010 (miss), mem returns 0xBEEF after 3 cycles -> mem_req 0→1 with mem_addr 0x0010, resp_data 0xBEEF; repeat load 0x0010 -> hit, resp_valid 1 cycle later, no mem_req.
- Store 0x0022=0x1234, mem_ready after 2 cycles -> mem_we=1, mem_wdata 0x1234; then load 0x0022 -> hit, 0x1234, no mem_req.
- Conflict: load 0x0004 then load 0x0204 (LINES=256, same index) -> both miss; reload 0x0004 -> miss again.
- flush with req_valid high in IDLE -> req_ready 0, request not accepted; subsequent load to previously cached 0x0010 -> miss.
- reset asserted during FILL -> mem_req low next cycle, no resp_valid, later load to same address misses.
- CACHE_STATS_EN: 2 misses + 3 hits -> miss_count 2, hit_count 3; stores leave both unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache:
// controller state encoding, default geometry and address-split helpers.
package cache_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LINES  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Line index: word address bits just above the byte-select bit.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned idx_w);
    return (addr >> 1) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: everything above the index field.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned idx_w);
    return addr >> (idx_w + 1);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache. One write port,
// single-cycle flush of all valid bits, combinational lookup.
module cache_line_store #(
  parameter int unsigned LINES  = 256,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [TAG_W-1:0]  i_rd_tag,
  output logic              o_hit_c,
  output logic [DATA_W-1:0] o_rd_data_c
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Valid bits: cleared by reset or flush, set on every line write.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit_c     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data_c = r_data[i_rd_idx];

endmodule

// File: rtl/dm_cache_wt.sv
// Direct-mapped, write-through, write-allocate cache with a valid/ready CPU
// port and a handshaked word-memory port. One outstanding request.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters
// for accepted loads.
module dm_cache_wt
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LINES  = DEF_LINES,
  parameter int unsigned IDX_W  = $clog2(LINES),
  parameter int unsigned TAG_W  = ADDR_W - IDX_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  state_t            r_state;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_accept;
  logic              w_flush;
  logic              w_hit;
  logic [DATA_W-1:0] w_rd_data;
  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_in_fill;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [TAG_W-1:0]  w_wr_tag;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_req_word;

  // Flush wins over a simultaneous request; both only act in IDLE.
  assign req_ready  = (r_state == IDLE) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_flush    = flush && (r_state == IDLE);

  assign w_req_idx  = IDX_W'(addr_index(32'(req_addr), IDX_W));
  assign w_req_tag  = TAG_W'(addr_tag(32'(req_addr), IDX_W));
  assign w_fill_idx = IDX_W'(addr_index(32'(r_mem_addr), IDX_W));
  assign w_fill_tag = TAG_W'(addr_tag(32'(r_mem_addr), IDX_W));
  assign w_req_word = {req_addr[ADDR_W-1:1], 1'b0};

  // Line write: stores allocate at acceptance, load misses on fill return.
  assign w_in_fill  = (r_state == FILL) && mem_ready;
  assign w_wr_en    = !reset && (w_in_fill || (w_accept && req_write));
  assign w_wr_idx   = w_in_fill ? w_fill_idx : w_req_idx;
  assign w_wr_tag   = w_in_fill ? w_fill_tag : w_req_tag;
  assign w_wr_data  = w_in_fill ? mem_rdata  : req_wdata;

  cache_line_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk         (clk),
    .i_reset     (reset),
    .i_flush     (w_flush),
    .i_we        (w_wr_en),
    .i_wr_idx    (w_wr_idx),
    .i_wr_tag    (w_wr_tag),
    .i_wr_data   (w_wr_data),
    .i_rd_idx    (w_req_idx),
    .i_rd_tag    (w_req_tag),
    .o_hit_c     (w_hit),
    .o_rd_data_c (w_rd_data)
  );

  // Controller FSM: hit responses, fill and write-through memory transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (req_write) begin
              r_state     <= WRITE;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_req_word;
              r_mem_wdata <= req_wdata;
            end else if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_rd_data;
            end else begin
              r_state    <= FILL;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_req_word;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= mem_rdata;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating hit/miss counters for accepted loads; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept && !req_write) begin
      if (w_hit) begin
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dm_cache_wt.sv
// Directed self-checking bench for dm_cache_wt (default geometry, LINES=256).
module tb_dm_cache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  dm_cache_wt dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input string tag);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    @(negedge clk);
  endtask

  // Hold off mem_ready for dly cycles, complete, and check the response.
  task automatic serve(input int dly, input logic [15:0] rd, input logic [15:0] exp_resp,
                       input string tag);
    repeat (dly) @(negedge clk);
    chk({tag, "_hold"}, 32'(mem_req), 32'd1);
    chk({tag, "_noresp"}, 32'(resp_valid), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, 32'(resp_data), 32'(exp_resp));
    chk({tag, "_reqlow"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_data), 32'd0);
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_mwe", 32'(mem_we), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_mwdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    // Load miss 0x0010, memory answers 0xBEEF three cycles later
    issue(1'b0, 16'h0010, 16'h0000, "ld10");
    chk("ld10_mreq", 32'(mem_req), 32'd1);
    chk("ld10_mwe", 32'(mem_we), 32'd0);
    chk("ld10_maddr", 32'(mem_addr), 32'h0010);
    chk("ld10_busy", 32'(req_ready), 32'd0);
    serve(3, 16'hBEEF, 16'hBEEF, "ld10");
    @(negedge clk);
    chk("ld10_pulse", 32'(resp_valid), 32'd0);

    // Repeat load hits in one cycle with no memory traffic
    issue(1'b0, 16'h0010, 16'h0000, "hit10");
    chk("hit10_rvalid", 32'(resp_valid), 32'd1);
    chk("hit10_rdata", 32'(resp_data), 32'h0000BEEF);
    chk("hit10_mreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("hit10_pulse", 32'(resp_valid), 32'd0);

    // Byte address 0x0011 maps to the same word
    issue(1'b0, 16'h0011, 16'h0000, "hit11");
    chk("hit11_rvalid", 32'(resp_valid), 32'd1);
    chk("hit11_rdata", 32'(resp_data), 32'h0000BEEF);
    chk("hit11_mreq", 32'(mem_req), 32'd0);
    @(negedge clk);

    // Store 0x0022 = 0x1234, write-through completes two cycles later
    issue(1'b1, 16'h0022, 16'h1234, "st22");
    chk("st22_mreq", 32'(mem_req), 32'd1);
    chk("st22_mwe", 32'(mem_we), 32'd1);
    chk("st22_maddr", 32'(mem_addr), 32'h0022);
    chk("st22_mwdata", 32'(mem_wdata), 32'h1234);
    serve(2, 16'hDEAD, 16'h0000, "st22");
`ifdef CACHE_STATS_EN
    chk("st_hits", hit_count, 32'd2);
    chk("st_misses", miss_count, 32'd1);
`endif
    @(negedge clk);

    // Load of the stored word hits
    issue(1'b0, 16'h0022, 16'h0000, "hit22");
    chk("hit22_rvalid", 32'(resp_valid), 32'd1);
    chk("hit22_rdata", 32'(resp_data), 32'h1234);
    chk("hit22_mreq", 32'(mem_req), 32'd0);
    @(negedge clk);

    // Conflict misses at index 2, requests issued back-to-back in resp cycles
    issue(1'b0, 16'h0004, 16'h0000, "ld04a");
    chk("ld04a_maddr", 32'(mem_addr), 32'h0004);
    serve(1, 16'hAAAA, 16'hAAAA, "ld04a");
    issue(1'b0, 16'h0204, 16'h0000, "ld204");
    chk("ld204_maddr", 32'(mem_addr), 32'h0204);
    serve(0, 16'hBBBB, 16'hBBBB, "ld204");
    issue(1'b0, 16'h0004, 16'h0000, "ld04b");
    chk("ld04b_miss", 32'(mem_req), 32'd1);
    chk("ld04b_maddr", 32'(mem_addr), 32'h0004);
    serve(0, 16'hAAAA, 16'hAAAA, "ld04b");
    @(negedge clk);
    chk("ld04b_pulse", 32'(resp_valid), 32'd0);
`ifdef CACHE_STATS_EN
    chk("cf_hits", hit_count, 32'd3);
    chk("cf_misses", miss_count, 32'd4);
`endif

    // Flush with a simultaneous request: request refused, lines invalidated
    flush     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0022;
    #1;
    chk("fl_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("fl_rvalid", 32'(resp_valid), 32'd0);
    chk("fl_mreq", 32'(mem_req), 32'd0);
    issue(1'b0, 16'h0010, 16'h0000, "fl10");
    chk("fl10_miss", 32'(mem_req), 32'd1);
    serve(0, 16'hBEEF, 16'hBEEF, "fl10");
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("fl_hits", hit_count, 32'd3);
    chk("fl_misses", miss_count, 32'd5);
`endif

    // Reset during FILL abandons the transaction
    issue(1'b0, 16'h0030, 16'h0000, "rf30");
    chk("rf30_mreq", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rf_mreq", 32'(mem_req), 32'd0);
    chk("rf_rvalid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rf_rvalid2", 32'(resp_valid), 32'd0);

    // mem_ready while no request is outstanding is ignored
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    @(negedge clk);
    chk("stray_rvalid", 32'(resp_valid), 32'd0);
    chk("stray_mreq", 32'(mem_req), 32'd0);
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;

    // Lines were invalidated by reset: both loads miss
    issue(1'b0, 16'h0030, 16'h0000, "rs30");
    chk("rs30_miss", 32'(mem_req), 32'd1);
    serve(0, 16'h5555, 16'h5555, "rs30");
    issue(1'b0, 16'h0010, 16'h0000, "rs10");
    chk("rs10_miss", 32'(mem_req), 32'd1);
    serve(0, 16'h7777, 16'h7777, "rs10");
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("end_hits", hit_count, 32'd0);
    chk("end_misses", miss_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
